// File: rtl/axis_join_reduce_pkg.sv
// Shared constants and types for the axis_join_reduce stream join/reduce engine.
package axis_join_pkg;

    localparam int OP_ADD     = 0;
    localparam int OP_MAX     = 'h1;
    localparam int COUNT_W    = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        RED_ADD = 1'b0,
        RED_MAX = 1'b1
    } reduce_op_e;

    // Default-width buffer entry; the top re-declares it at its own DATA_W and
    // hands it to the FIFO through the entry_t type parameter.
    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/axis_join_reduce_if.sv
// AXI-Stream bundle with LANES parallel channels; master drives data/valid, slave drives ready.
interface axis_join_reduce_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 32
);
    logic [LANES*DATA_W-1:0]   TDATA;
    logic [LANES*DATA_W/8-1:0] TKEEP;
    logic [LANES-1:0]          TLAST;
    logic [LANES-1:0]          TVALID;
    logic [LANES-1:0]          TREADY;

    modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axis_join_fifo.sv
// Single-channel synchronous FIFO with registered ready (not full) and empty flags.
module axis_join_fifo import axis_join_pkg::*; #(
    parameter type entry_t = fifo_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    output logic   in_ready,
    input  logic   pop,
    output entry_t dout,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    // ready is held low through reset and derived from next occupancy, so a
    // pop on a full FIFO only reopens it one cycle later.
    always_comb begin
        do_push  = push & ready_q;
        do_pop   = pop & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        ready_d = (count_d != FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout     = mem_q[rd_ptr_q];
    assign in_ready = ready_q;
    assign empty    = empty_q;

endmodule

// File: rtl/axis_join_reduce.sv
// N-channel AXI-Stream join: buffers each channel, reduces heads (add/max), forwards TLAST close tokens.
// Optional close-token alignment check is enabled by defining AXIS_JOIN_MISMATCH_CHECK_EN.
module axis_join_reduce import axis_join_pkg::*; #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int OP_MODE    = OP_ADD
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    axis_join_reduce_if.slave   s,
    axis_join_reduce_if.master  m,
    output logic [COUNT_W-1:0]  elem_count,
    output logic                done,
    output logic                err_mismatch
);
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam reduce_op_e OP = (OP_MODE == OP_MAX) ? RED_MAX : RED_ADD;

    entry_t              head [NUM_CH];
    logic [NUM_CH-1:0]   empty, pop, head_last;
    logic                all_valid, all_last, can_load, fire, mixed, load, close_hs;
    logic [DATA_W-1:0]   red;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                done_q, done_d;
    logic                unused_keep;

    assign unused_keep = ^s.TKEEP;

    // Handshakes: a beat moves on a channel when TVALID and TREADY are both high
    // at a rising edge; TREADY never depends combinationally on TVALID or m.TREADY.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        entry_t din;
        assign din = {s.TLAST[i], s.TDATA[i*DATA_W +: DATA_W]};
        axis_join_fifo #(.entry_t(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .push     (s.TVALID[i]),
            .din      (din),
            .in_ready (s.TREADY[i]),
            .pop      (pop[i]),
            .dout     (head[i]),
            .empty    (empty[i])
        );
        assign head_last[i] = head[i].last;
    end

    always_comb begin
        red = head[0].data;
        for (int i = 1; i < NUM_CH; i++) begin
            if (OP == RED_MAX) begin
                red = (head[i].data > red) ? head[i].data : red;
            end else begin
                red = red + head[i].data;
            end
        end
    end

    assign all_valid = ~|empty;
    assign all_last  = &head_last;
    assign can_load  = ~m_valid_q | m.TREADY[0];
    assign fire      = all_valid & can_load;

`ifdef AXIS_JOIN_MISMATCH_CHECK_EN
    logic err_q, err_d;
    // Mixed heads: drop the data heads, keep the close tokens waiting.
    assign mixed = (|head_last) & ~all_last;
    always_comb begin
        err_d = err_q | (fire & mixed);
    end
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) err_q <= 1'b0;
        else           err_q <= err_d;
    end
    assign err_mismatch = err_q;
`else
    assign mixed        = 1'b0;
    assign err_mismatch = 1'b0;
`endif

    assign pop  = fire ? (mixed ? ~head_last : {NUM_CH{1'b1}}) : '0;
    assign load = fire & ~mixed;

    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        count_d   = count_q;
        done_d    = done_q;
        close_hs  = m_valid_q & m.TREADY[0] & m_last_q;
        if (m_valid_q & m.TREADY[0]) m_valid_d = 1'b0;
        if (close_hs) done_d = 1'b1;
        if (load) begin
            m_valid_d = 1'b1;
            m_last_d  = all_last;
            m_data_d  = all_last ? '0 : red;
            if (!all_last) begin
                // A data beat after a finished stream opens a fresh one.
                if (done_q | close_hs) begin
                    count_d = COUNT_W'(1);
                    done_d  = 1'b0;
                end else if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign m.TDATA     = m_data_q;
    assign m.TKEEP     = '1;
    assign m.TLAST[0]  = m_last_q;
    assign m.TVALID[0] = m_valid_q;
    assign elem_count  = count_q;
    assign done        = done_q;

endmodule

// File: doc/axis_join_reduce.md
# axis_join_reduce

N-channel AXI-Stream join-and-reduce engine, the parametrised successor of the two-input stream-add kernel datapath. It buffers each input channel in a small FIFO and fires when every channel has a head element. On each fire it reduces the heads element-wise (wrapping add or unsigned max) and emits one output beat. It propagates the TLAST close-token protocol: a beat with TLAST=1 ends the stream, and its data is ignored. It sits between the kernel's AXI-Stream ports and the control block, which reads `elem_count`, `done` and `err_mismatch`.

## Interface
- `NUM_CH`, default 2: number of input channels, range 2..8.
- `DATA_W`, default 32: element width in bits, a multiple of 8.
- `FIFO_DEPTH`, default 4: per-channel buffer depth, a power of two ≥ 2.
- `OP_MODE`, default 0: 0 = wrapping add modulo 2^DATA_W; 1 = unsigned max.
- Clock and reset: one clock; reset is synchronous and active-low.
- `ap_clk` in 1: clock.
- `ap_rst_n` in 1: synchronous, active-low reset.
- `s_TDATA` in NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `s_TKEEP` in NUM_CH*DATA_W/8: accepted but ignored; all bytes are treated as valid.
- `s_TLAST` in NUM_CH: per-channel close-token flag.
- `s_TVALID` in NUM_CH: per-channel valid.
- `s_TREADY` out NUM_CH: per-channel ready.
- `m_TDATA` out DATA_W: reduced result.
- `m_TKEEP` out DATA_W/8: always all ones while `m_TVALID`=1.
- `m_TLAST` out 1: marks the output close token.
- `m_TVALID` out 1: output valid.
- `m_TREADY` in 1: output ready.
- `elem_count` out 32: number of data beats emitted in the current stream.
- `done` out 1: sticky; the close token has been accepted downstream.
- `err_mismatch` out 1: sticky; close tokens arrived on the channels out of step.

## Operation
- **Input acceptance.** `s_TREADY[i]` = !full[i], registered, with no combinational path from `m_TREADY`. Push on `s_TVALID[i] & s_TREADY[i]`. FIFO entry = {TLAST, TDATA}.
- **Fire condition.** fire = all heads non-empty & (!m_TVALID | m_TREADY). Fire pops the heads and loads the output register.
- **All heads TLAST=0 (data beat).**
  - m_TDATA = reduction of all heads; m_TLAST=0.
  - `elem_count` += 1, saturating at 2^32-1.
- **All heads TLAST=1 (close token).**
  - m_TDATA=0, m_TLAST=1.
  - `done` sets on the cycle the token handshakes (m_TVALID & m_TREADY & m_TLAST).
- **New stream after done.** The first data fire after `done` clears `done`, sets `elem_count` to 1 and starts a new stream. `err_mismatch` stays set.
- **Mixed heads.** Behaviour depends on the configuration (see Configuration).
- **Reduction arithmetic.**
  - Add: unsigned sum truncated to DATA_W bits.
  - Max: unsigned compare. Equal values give identical output, so tie order does not matter.

## Timing
- **Reset values.** All FIFOs empty. `s_TREADY`=all ones on the first cycle after reset deasserts (0 while `ap_rst_n`=0). `m_TVALID`=0, `m_TDATA`=0, `m_TLAST`=0, `elem_count`=0, `done`=0, `err_mismatch`=0.
- **Latency.** A beat accepted at edge k is at the FIFO head after k. The last-arriving channel's beat accepted at edge k gives m_TVALID=1 after edge k+1 (2 cycles).
- **Throughput.** 1 beat per cycle when all channels stream and `m_TREADY`=1.
- **Output stability.** `m_TDATA`, `m_TLAST` and `m_TVALID` hold steady while m_TVALID & !m_TREADY.
- **Full FIFO.** `s_TREADY` is low when the FIFO is full, even if a pop occurs in the same cycle. It rises the cycle after the pop.
- **Simultaneous push and pop on a non-full FIFO.** Occupancy is unchanged.
- **Reset mid-stream.** All buffered and in-flight beats are discarded. No output beat is emitted for them.

## Configuration
- **`AXIS_JOIN_MISMATCH_CHECK_EN` defined.**
  - On a mixed fire: `err_mismatch` sets, the TLAST=0 heads are popped and dropped, and the TLAST=1 heads are held.
  - No output beat is produced and `elem_count` is unchanged.
  - This repeats until all heads are close tokens, then the close token is emitted normally.
- **Macro undefined.**
  - A mixed fire is treated as a data beat: all heads are popped and their TDATA reduced, m_TLAST=0, `elem_count` += 1.
  - `err_mismatch` is tied to 0.

## Structure
- **Package `axis_join_pkg`:**
  - `OP_ADD`=0 and `OP_MAX`=0x1 constants;
  - a `reduce_op_e` enum;
  - a parametrised `fifo_entry_t` struct {last, data};
  - a `COUNT_W`=32 constant.
- **Sub-module `axis_join_fifo`:** a single-channel synchronous FIFO with registered full/empty, instantiated NUM_CH times via generate.
- **Top level:** join logic, the reduction tree and the output register stay in the top level.

## Test plan
- **Basic add, matching the existing kernel test.** NUM_CH=2, add. Stream a=0..4 and b=1..5, then close tokens on both. Output is 1,3,5,7,9, then m_TLAST=1 with m_TDATA=0. `elem_count`=5, `done`=1.
- **Four channels, max.** NUM_CH=4, OP_MODE=1. Head values {7,0xFFFFFFFF,3,9} give 0xFFFFFFFF. Adding 0xFFFFFFFF+1 in add mode gives 0.
- **Backpressure.** Hold `m_TREADY`=0 for 10 cycles with continuous input. Each `s_TREADY` falls after FIFO_DEPTH+1 accepts. The output stays stable. After release, all beats arrive in order with no loss or duplication.
- **Skewed arrival.** Channel 1 lags by 6 cycles. The first output appears 2 cycles after channel 1's first accept, with the correct sums.
- **Mismatch, macro on.** Channel 0 sends close after 2 beats and channel 1 after 4. `err_mismatch`=1, 2 data beats are emitted, then the close token. `elem_count`=2.
- **Reset mid-stream, then new stream.** Assert `ap_rst_n`=0 for 1 cycle mid-stream. All outputs return to their reset values. A new 3-beat stream then gives `elem_count`=3 and `done`=1.
